// File: rtl/riscv_defines.sv
// Shared types for the interrupt arbiter: privilege levels and arbiter FSM states.
package riscv_defines;

    localparam int unsigned IRQ_ID_W = 5;

    typedef enum logic [1:0] {
        PRIV_LVL_M = 2'b11,
        PRIV_LVL_H = 2'b10,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_U = 2'b00
    } PrivLvl_t;

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        IRQ_PENDING = 2'b01,
        IRQ_DONE    = 2'b10
    } irq_ctrl_state_t;

endpackage

// File: rtl/riscv_irq_prio_enc.sv
// Priority encoder: reports the highest-index set bit of the request vector.
module riscv_irq_prio_enc
    import riscv_defines::*;
#(
    parameter int unsigned NUM_IRQ = 32
) (
    input  logic [NUM_IRQ-1:0]  irq_i,
    output logic                valid_o,
    output logic [IRQ_ID_W-1:0] idx_o
);

    // Ascending scan: the last set bit seen is the highest index.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (irq_i[i]) begin
                valid_o = 1'b1;
                idx_o   = IRQ_ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/riscv_irq_arbiter.sv
// Interrupt arbiter: captures edge/level interrupts, picks the highest eligible line and
// runs a request/ack handshake with the core controller.
module riscv_irq_arbiter
    import riscv_defines::*;
#(
    parameter int unsigned        NUM_IRQ     = 32,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK   = '0,
    parameter bit                 PULP_SECURE = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_IRQ-1:0]  irq_i,
    input  logic [NUM_IRQ-1:0]  irq_en_i,
    input  logic [NUM_IRQ-1:0]  irq_sec_i,
    input  logic                m_IE_i,
    input  logic                u_IE_i,
    input  PrivLvl_t            current_priv_lvl_i,
    output logic                irq_req_ctrl_o,
    output logic [IRQ_ID_W-1:0] irq_id_ctrl_o,
    output logic                irq_sec_ctrl_o,
    input  logic                ctrl_ack_i,
    input  logic                ctrl_kill_i,
    output logic [NUM_IRQ-1:0]  irq_pending_o
);

    logic [NUM_IRQ-1:0]  r_irq_prev;
    logic [NUM_IRQ-1:0]  r_edge_pend;
    irq_ctrl_state_t     r_state;
    logic [IRQ_ID_W-1:0] r_irq_id;
    logic                r_irq_sec;

    logic [NUM_IRQ-1:0]  w_rise;
    logic [NUM_IRQ-1:0]  w_clr;
    logic [NUM_IRQ-1:0]  w_edge_pend_d;
    logic [NUM_IRQ-1:0]  w_pending;
    logic [NUM_IRQ-1:0]  w_eligible;
    logic                w_sel_valid;
    logic [IRQ_ID_W-1:0] w_sel_idx;
    logic                w_sel_sec;
    logic                w_global_en;
    logic                w_ack_clr;
    irq_ctrl_state_t     w_state_d;
    logic [IRQ_ID_W-1:0] w_irq_id_d;
    logic                w_irq_sec_d;

    // Pending view: edge lines come from the sticky register, level lines straight from irq_i.
    always_comb begin
        w_rise        = irq_i & ~r_irq_prev & EDGE_MASK;
        w_pending     = (r_edge_pend & EDGE_MASK) | (irq_i & ~EDGE_MASK);
        w_eligible    = w_pending & irq_en_i;
        // A fresh rising edge beats a same-cycle ack clear.
        w_edge_pend_d = ((r_edge_pend & ~w_clr) | w_rise) & EDGE_MASK;
    end

    riscv_irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio_enc (
        .irq_i   (w_eligible),
        .valid_o (w_sel_valid),
        .idx_o   (w_sel_idx)
    );

    // Secure attribute of the selected line and the global enable qualifier.
    always_comb begin
        w_sel_sec = 1'b0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (w_sel_idx == IRQ_ID_W'(i)) begin
                w_sel_sec = irq_sec_i[i];
            end
        end
        if (PULP_SECURE) begin
            w_global_en = ((u_IE_i | w_sel_sec) && (current_priv_lvl_i == PRIV_LVL_U)) ||
                          (m_IE_i && (current_priv_lvl_i == PRIV_LVL_M));
        end else begin
            w_global_en = m_IE_i;
        end
    end

    // Handshake FSM next state and latch updates.
    always_comb begin
        w_state_d   = r_state;
        w_irq_id_d  = r_irq_id;
        w_irq_sec_d = r_irq_sec;
        w_ack_clr   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_global_en && w_sel_valid) begin
                    w_state_d   = IRQ_PENDING;
                    w_irq_id_d  = w_sel_idx;
                    w_irq_sec_d = w_sel_sec;
                end
            end
            IRQ_PENDING: begin
                if (ctrl_ack_i) begin
                    w_state_d = IRQ_DONE;
                    w_ack_clr = 1'b1;
                end else if (ctrl_kill_i) begin
                    // Kill leaves pending bits alone so the line is re-arbitrated.
                    w_state_d = IDLE;
                end
            end
            IRQ_DONE: begin
                w_state_d   = IDLE;
                w_irq_sec_d = 1'b0;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // Ack clears only the latched line, and only if it is edge-triggered.
    always_comb begin
        w_clr = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            w_clr[i] = w_ack_clr && (r_irq_id == IRQ_ID_W'(i)) && EDGE_MASK[i];
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_irq_prev  <= '0;
            r_edge_pend <= '0;
            r_state     <= IDLE;
            r_irq_id    <= '0;
            r_irq_sec   <= 1'b0;
        end else begin
            r_irq_prev  <= irq_i;
            r_edge_pend <= w_edge_pend_d;
            r_state     <= w_state_d;
            r_irq_id    <= w_irq_id_d;
            r_irq_sec   <= w_irq_sec_d;
        end
    end

    // Outputs are straight from registered state plus the combinational pending view.
    always_comb begin
        irq_req_ctrl_o = (r_state == IRQ_PENDING);
        irq_id_ctrl_o  = r_irq_id;
        irq_sec_ctrl_o = r_irq_sec;
        irq_pending_o  = w_pending;
    end

endmodule

// File: tb/tb_riscv_irq_arbiter.sv
// Bench for riscv_irq_arbiter: two instances (non-secure and secure) share stimulus and
// are checked every cycle against a rule-level model, plus hand-computed spot checks.
module tb_riscv_irq_arbiter;
    import riscv_defines::*;

    localparam logic [31:0] EDGE = 32'h0000_0208; // lines 3 and 9 edge, rest level

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] irq, en, sec_i;
    logic        mie, uie, ack, kill;
    PrivLvl_t    priv;

    logic        req  [2];
    logic [4:0]  id   [2];
    logic        sec  [2];
    logic [31:0] pend [2];

    logic [31:0] edge_v;
    assign edge_v = EDGE;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    riscv_irq_arbiter #(
        .NUM_IRQ     (32),
        .EDGE_MASK   (EDGE),
        .PULP_SECURE (1'b0)
    ) u_dut0 (
        .clk                (clk),
        .rst_n              (rst_n),
        .irq_i              (irq),
        .irq_en_i           (en),
        .irq_sec_i          (sec_i),
        .m_IE_i             (mie),
        .u_IE_i             (uie),
        .current_priv_lvl_i (priv),
        .irq_req_ctrl_o     (req[0]),
        .irq_id_ctrl_o      (id[0]),
        .irq_sec_ctrl_o     (sec[0]),
        .ctrl_ack_i         (ack),
        .ctrl_kill_i        (kill),
        .irq_pending_o      (pend[0])
    );

    riscv_irq_arbiter #(
        .NUM_IRQ     (32),
        .EDGE_MASK   (EDGE),
        .PULP_SECURE (1'b1)
    ) u_dut1 (
        .clk                (clk),
        .rst_n              (rst_n),
        .irq_i              (irq),
        .irq_en_i           (en),
        .irq_sec_i          (sec_i),
        .m_IE_i             (mie),
        .u_IE_i             (uie),
        .current_priv_lvl_i (priv),
        .irq_req_ctrl_o     (req[1]),
        .irq_id_ctrl_o      (id[1]),
        .irq_sec_ctrl_o     (sec[1]),
        .ctrl_ack_i         (ack),
        .ctrl_kill_i        (kill),
        .irq_pending_o      (pend[1])
    );

    task automatic chk(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %h want %h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Model state: 0 = waiting, 1 = requesting, 2 = one-cycle post-ack.
    int          m_st   [2];
    logic [4:0]  m_id   [2];
    logic        m_sec  [2];
    logic [31:0] m_pend [2];
    logic [31:0] m_prev;

    always @(posedge clk) begin
        logic [31:0] rise, elig, clr;
        int          sel;
        logic        ge;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_st[k] = 0; m_id[k] = '0; m_sec[k] = 1'b0; m_pend[k] = '0;
            end
            m_prev = '0;
        end else begin
            rise = irq & ~m_prev & edge_v;
            for (int k = 0; k < 2; k++) begin
                elig = (m_pend[k] | (irq & ~edge_v)) & en;
                sel  = 31;
                while (sel > 0 && !elig[sel]) sel--;
                if (k == 0) ge = mie;
                else ge = ((uie || sec_i[sel]) && priv == PRIV_LVL_U) ||
                          (mie && priv == PRIV_LVL_M);
                clr = '0;
                case (m_st[k])
                    0: if (ge && elig != 0) begin
                        m_st[k] = 1; m_id[k] = 5'(sel); m_sec[k] = sec_i[sel];
                    end
                    1: if (ack) begin
                        m_st[k] = 2;
                        if (edge_v[m_id[k]]) clr = 32'd1 << m_id[k];
                    end else if (kill) begin
                        m_st[k] = 0;
                    end
                    default: begin m_st[k] = 0; m_sec[k] = 1'b0; end
                endcase
                m_pend[k] = (m_pend[k] & ~clr) | rise;
            end
            m_prev = irq;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk("model_req", k, 32'(req[k]), 32'(m_st[k] == 1));
                chk("model_id", k, 32'(id[k]), 32'(m_id[k]));
                chk("model_sec", k, 32'(sec[k]), 32'(m_sec[k]));
                chk("model_pend", k, pend[k], m_pend[k] | (irq & ~edge_v));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; irq = '0; en = '0; sec_i = '0;
        mie = 1'b1; uie = 1'b0; ack = 1'b0; kill = 1'b0; priv = PRIV_LVL_M;
        @(posedge clk);
        #1 chk_en = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("rst_req", k, 32'(req[k]), 0);
            chk("rst_id", k, 32'(id[k]), 0);
            chk("rst_pend", k, pend[k], 0);
        end
        rst_n = 1'b1;

        // Level line 5: request next cycle, re-request 2 cycles after ack.
        en = '1; irq = 32'h20;
        tick();
        chk("lvl_req", 0, 32'(req[0]), 1);
        chk("lvl_id", 0, 32'(id[0]), 5);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("lvl_done_req", 0, 32'(req[0]), 0);
        tick();
        chk("lvl_idle_req", 0, 32'(req[0]), 0);
        tick();
        chk("lvl_rereq", 0, 32'(req[0]), 1);
        irq = '0; kill = 1'b1; tick(); kill = 1'b0; tick();
        chk("lvl_quiet", 0, 32'(req[0]), 0);

        // Edge line 3: sticky pending, cleared by ack, no re-request.
        irq = 32'h8; tick();
        chk("edge_pend", 0, pend[0], 32'h8);
        chk("edge_noreq_yet", 0, 32'(req[0]), 0);
        irq = '0; tick();
        chk("edge_req", 0, 32'(req[0]), 1);
        chk("edge_id", 0, 32'(id[0]), 3);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("edge_clr", 0, pend[0], 0);
        tick(); tick();
        chk("edge_norereq", 0, 32'(req[0]), 0);

        // Lines 2 (level) and 9 (edge) together: 9 wins, then 2; id holds while requesting.
        en = '0; irq = 32'h204; tick();
        en = '1; tick();
        chk("prio_id9", 0, 32'(id[0]), 9);
        irq = 32'h4; en = 32'h4; tick();
        chk("prio_hold", 0, 32'(id[0]), 9);
        en = '1; ack = 1'b1; tick(); ack = 1'b0;
        chk("prio_clr9", 0, pend[0], 32'h4);
        tick(); tick();
        chk("prio_id2", 0, 32'(id[0]), 2);
        irq = '0; kill = 1'b1; tick(); kill = 1'b0; tick();

        // Ack and kill together go through DONE.
        irq = 32'h20; tick();
        ack = 1'b1; kill = 1'b1; tick(); ack = 1'b0; kill = 1'b0;
        chk("ackkill_req", 0, 32'(req[0]), 0);
        tick();
        chk("ackkill_idle", 0, 32'(req[0]), 0);
        tick();
        chk("ackkill_rereq", 0, 32'(req[0]), 1);
        irq = '0; kill = 1'b1; tick(); kill = 1'b0; tick();

        // Kill alone keeps edge pending and re-requests.
        irq = 32'h8; tick(); irq = '0; tick();
        kill = 1'b1; tick(); kill = 1'b0;
        chk("kill_req", 0, 32'(req[0]), 0);
        chk("kill_pend", 0, pend[0], 32'h8);
        tick();
        chk("kill_rereq", 0, 32'(req[0]), 1);
        chk("kill_id", 0, 32'(id[0]), 3);
        ack = 1'b1; tick(); ack = 1'b0; tick(); tick();

        // New edge in the ack cycle survives the clear.
        irq = 32'h8; tick(); irq = '0; tick();
        ack = 1'b1; irq = 32'h8; tick(); ack = 1'b0; irq = '0;
        chk("rise_wins", 0, pend[0], 32'h8);
        tick(); tick();
        chk("rise_rereq", 0, 32'(req[0]), 1);
        ack = 1'b1; tick(); ack = 1'b0; tick(); tick();

        // Secure line in U mode with u_IE off.
        priv = PRIV_LVL_U; mie = 1'b0; uie = 1'b0; sec_i = 32'h10; irq = 32'h10;
        tick();
        chk("sec_req", 1, 32'(req[1]), 1);
        chk("sec_id", 1, 32'(id[1]), 4);
        chk("sec_bit", 1, 32'(sec[1]), 1);
        chk("nonsec_req", 0, 32'(req[0]), 0);
        irq = '0; kill = 1'b1; tick(); kill = 1'b0;
        sec_i = '0; irq = 32'h10; tick(); tick();
        chk("sec0_noreq", 1, 32'(req[1]), 0);
        irq = '0; priv = PRIV_LVL_M; mie = 1'b1; tick();

        // Reset in the middle of a request.
        sec_i = 32'h200; irq = 32'h200; tick(); irq = '0; tick();
        chk("mid_id", 0, 32'(id[0]), 9);
        chk("mid_sec", 1, 32'(sec[1]), 1);
        rst_n = 1'b0; tick();
        for (int k = 0; k < 2; k++) begin
            chk("rstmid_req", k, 32'(req[k]), 0);
            chk("rstmid_id", k, 32'(id[k]), 0);
            chk("rstmid_sec", k, 32'(sec[k]), 0);
            chk("rstmid_pend", k, pend[k], 0);
        end
        rst_n = 1'b1; sec_i = '0; tick(); tick();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
